// File: rtl/clock_set_ctrl.sv
// Run/set controller for the HH:MM:SS timer chain: 1 Hz tick prescaler,
// debounced mode/inc buttons, and the hour/minute/second edit FSM that
// commits all three fields to the timers in one load pulse.
module clock_set_ctrl #(
   parameter int unsigned CLK_FREQ     = 25_000_000,
   parameter int unsigned INIT_HOUR    = 8,
   parameter int unsigned INIT_MINUTE  = 12,
   parameter int unsigned INIT_SECOND  = 17,
   parameter int unsigned DEBOUNCE_CYC = 250_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run_en,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_sec,
   output logic       tick,
   output logic       load,
   output logic [4:0] load_hour,
   output logic [5:0] load_min,
   output logic [5:0] load_sec,
   output logic [1:0] mode,
   output logic       blink
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } state_t;

   localparam int unsigned PW = $clog2(CLK_FREQ);
   localparam int unsigned DW = $clog2(DEBOUNCE_CYC);
   localparam int unsigned BQ = CLK_FREQ / 4;
   localparam int unsigned BW = $clog2(BQ + 1);

   localparam logic [PW-1:0] PS_MAX = PW'(CLK_FREQ - 1);
   localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYC - 1);
   localparam logic [BW-1:0] BC_MAX = BW'(BQ - 1);

   // bit 0 = mode button, bit 1 = inc button
   logic [1:0]    btn_raw;
   logic [1:0]    sync1, sync2, db, evt;
   logic [DW-1:0] db_cnt [2];
   logic          mode_evt, inc_evt;

   state_t        state_q, state_d;
   logic [4:0]    eh_q, eh_d;
   logic [5:0]    em_q, em_d, es_q, es_d;
   logic [PW-1:0] ps_q, ps_d;
   logic [BW-1:0] bc_q, bc_d;
   logic          blink_q, blink_d;
   logic          load_q, load_d;
   logic          tick_q, tick_d;
   logic          init_pend;

   assign btn_raw  = {btn_inc, btn_mode};
   assign mode_evt = evt[0];
   assign inc_evt  = evt[1] & ~evt[0];

   // Synchronise both buttons, accept a new level after DEBOUNCE_CYC stable cycles, pulse on press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         evt   <= '0;
         for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         for (int unsigned i = 0; i < 2; i++) begin
            evt[i] <= 1'b0;
            if (sync2[i] != db[i]) begin
               if (db_cnt[i] == DB_MAX) begin
                  db[i]     <= sync2[i];
                  evt[i]    <= sync2[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + DW'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // Next-state, edit fields, prescaler, blink and pulse outputs
   always_comb begin
      state_d = state_q;
      eh_d    = eh_q;
      em_d    = em_q;
      es_d    = es_q;
      ps_d    = ps_q;
      bc_d    = bc_q;
      blink_d = blink_q;
      load_d  = init_pend;
      tick_d  = 1'b0;

      if (state_q != RUN) begin
         if (bc_q == BC_MAX) begin
            bc_d    = '0;
            blink_d = ~blink_q;
         end else begin
            bc_d = bc_q + BW'(1);
         end
      end

      case (state_q)
         RUN: begin
            blink_d = 1'b0;
            bc_d    = '0;
            if (run_en) begin
               if (ps_q == PS_MAX) begin
                  ps_d   = '0;
                  tick_d = 1'b1;
               end else begin
                  ps_d = ps_q + PW'(1);
               end
            end
            if (mode_evt) begin
               state_d = SET_H;
               eh_d    = cur_hour;
               em_d    = cur_min;
               es_d    = cur_sec;
               blink_d = 1'b1;
               bc_d    = '0;
            end
         end
         SET_H: begin
            if (mode_evt)     state_d = SET_M;
            else if (inc_evt) eh_d = (eh_q == 5'd23) ? 5'd0 : eh_q + 5'd1;
         end
         SET_M: begin
            if (mode_evt)     state_d = SET_S;
            else if (inc_evt) em_d = (em_q == 6'd59) ? 6'd0 : em_q + 6'd1;
         end
         SET_S: begin
            if (mode_evt) begin
               state_d = RUN;
               load_d  = 1'b1;
               ps_d    = '0;
               blink_d = 1'b0;
               bc_d    = '0;
            end else if (inc_evt) begin
               es_d = (es_q == 6'd59) ? 6'd0 : es_q + 6'd1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Control and datapath registers; init_pend forces the INIT load on the first edge after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         eh_q      <= 5'(INIT_HOUR);
         em_q      <= 6'(INIT_MINUTE);
         es_q      <= 6'(INIT_SECOND);
         ps_q      <= '0;
         bc_q      <= '0;
         blink_q   <= 1'b0;
         load_q    <= 1'b0;
         tick_q    <= 1'b0;
         init_pend <= 1'b1;
      end else begin
         state_q   <= state_d;
         eh_q      <= eh_d;
         em_q      <= em_d;
         es_q      <= es_d;
         ps_q      <= ps_d;
         bc_q      <= bc_d;
         blink_q   <= blink_d;
         load_q    <= load_d;
         tick_q    <= tick_d;
         init_pend <= 1'b0;
      end
   end

   assign tick      = tick_q;
   assign load      = load_q;
   assign load_hour = eh_q;
   assign load_min  = em_q;
   assign load_sec  = es_q;
   assign mode      = state_q;
   assign blink     = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl with CLK_FREQ=8, DEBOUNCE_CYC=4.
// Stimulus queues expected load/tick pulses with the cycle they must appear in;
// the monitor matches every pulse the DUT emits against that queue.
module tb_clock_set_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run_en;
   logic       btn_mode;
   logic       btn_inc;
   logic [4:0] cur_hour;
   logic [5:0] cur_min;
   logic [5:0] cur_sec;
   logic       tick;
   logic       load;
   logic [4:0] load_hour;
   logic [5:0] load_min;
   logic [5:0] load_sec;
   logic [1:0] mode;
   logic       blink;

   typedef struct {
      bit          is_load;
      int unsigned cyc;
      int unsigned h;
      int unsigned m;
      int unsigned s;
   } exp_t;

   exp_t        q[$];
   int unsigned cyc = 0;
   int unsigned n_pass = 0;
   int unsigned n_chk = 0;

   clock_set_ctrl #(
      .CLK_FREQ(8),
      .INIT_HOUR(8),
      .INIT_MINUTE(12),
      .INIT_SECOND(17),
      .DEBOUNCE_CYC(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .run_en(run_en),
      .btn_mode(btn_mode),
      .btn_inc(btn_inc),
      .cur_hour(cur_hour),
      .cur_min(cur_min),
      .cur_sec(cur_sec),
      .tick(tick),
      .load(load),
      .load_hour(load_hour),
      .load_min(load_min),
      .load_sec(load_sec),
      .mode(mode),
      .blink(blink)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
   endtask

   task automatic fail_note(input string name, input int act, input int exp);
      n_chk++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
   endtask

   task automatic exp_load(input int unsigned c, input int unsigned h,
                           input int unsigned m, input int unsigned s);
      exp_t e;
      e.is_load = 1'b1; e.cyc = c; e.h = h; e.m = m; e.s = s;
      q.push_back(e);
   endtask

   task automatic exp_tick(input int unsigned c);
      exp_t e;
      e.is_load = 1'b0; e.cyc = c; e.h = 0; e.m = 0; e.s = 0;
      q.push_back(e);
   endtask

   // Press: raw high 6 cycles (event lands at start+7), then released and settled
   task automatic press(input bit do_mode, input bit do_inc);
      btn_mode = do_mode;
      btn_inc  = do_inc;
      repeat (6) @(negedge clk);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   // Monitor: every load/tick pulse must match the head of the expectation queue
   always @(negedge clk) begin
      if (load && tick) fail_note("load_tick_overlap", 1, 0);
      if (load || tick) begin
         if (q.size() == 0 || q[0].cyc != cyc) begin
            fail_note(load ? "unexpected_load" : "unexpected_tick", int'(cyc),
                      (q.size() == 0) ? -1 : int'(q[0].cyc));
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.is_load)
               chk("load_pulse", {load, tick, 3'b0, load_hour, 2'b0, load_min, 2'b0, load_sec},
                   {1'b1, 1'b0, 3'b0, e.h[4:0], 2'b0, e.m[5:0], 2'b0, e.s[5:0]});
            else
               chk("tick_pulse", {load, tick}, 2'b01);
         end
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
         fail_note(q[0].is_load ? "missed_load" : "missed_tick", -1, int'(q[0].cyc));
         void'(q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned c0, n;
      rst_n    = 1'b0;
      run_en   = 1'b1;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      cur_hour = 5'd0;
      cur_min  = 6'd0;
      cur_sec  = 6'd0;
      repeat (3) @(negedge clk);
      chk("rst_mode", mode, 0);
      chk("rst_load", load, 0);
      chk("rst_tick", tick, 0);
      chk("rst_blink", blink, 0);
      chk("rst_edit", {load_hour, load_min, load_sec}, {5'd8, 6'd12, 6'd17});

      // Release: INIT load on first edge, ticks every 8 cycles
      rst_n = 1'b1;
      c0 = cyc;
      exp_load(c0 + 1, 8, 12, 17);
      exp_tick(c0 + 8);
      exp_tick(c0 + 16);
      repeat (20) @(negedge clk);

      // Pause with prescaler at 4 for 20 cycles, then 4 remaining cycles to the next tick
      run_en = 1'b0;
      repeat (20) @(negedge clk);
      run_en = 1'b1;
      exp_tick(c0 + 44);
      repeat (6) @(negedge clk);
      run_en = 1'b0;               // prescaler held at 2 from here
      chk("run_mode", mode, 0);
      chk("run_blink", blink, 0);

      // Enter SET_H with a snapshot of 10:59:30
      cur_hour = 5'd10;
      cur_min  = 6'd59;
      cur_sec  = 6'd30;
      btn_mode = 1'b1;
      repeat (6) @(negedge clk);
      chk("mode_latency_before", mode, 0);
      btn_mode = 1'b0;
      @(negedge clk);
      chk("enter_set_h", mode, 1);
      chk("snapshot", {load_hour, load_min, load_sec}, {5'd10, 6'd59, 6'd30});
      chk("blink_entry", blink, 1);
      repeat (2) @(negedge clk);
      chk("blink_toggle0", blink, 0);
      repeat (2) @(negedge clk);
      chk("blink_toggle1", blink, 1);
      repeat (3) @(negedge clk);

      for (int i = 0; i < 13; i++) press(1'b0, 1'b1);
      chk("hour_23", load_hour, 23);
      press(1'b0, 1'b1);
      chk("hour_wrap", load_hour, 0);
      chk("hour_no_carry", {load_min, load_sec}, {6'd59, 6'd30});

      press(1'b1, 1'b0);
      chk("enter_set_m", mode, 2);
      press(1'b0, 1'b1);
      chk("min_wrap", {load_hour, load_min, load_sec}, {5'd0, 6'd0, 6'd30});
      press(1'b1, 1'b0);
      chk("enter_set_s", mode, 3);

      // Commit: load 0:00:30, prescaler cleared, tick 8 cycles after load
      run_en = 1'b1;
      n = cyc;
      exp_load(n + 7, 0, 0, 30);
      exp_tick(n + 15);
      press(1'b1, 1'b0);
      chk("commit_mode", mode, 0);
      repeat (2) @(negedge clk);
      run_en = 1'b0;
      chk("commit_blink", blink, 0);

      // Short glitch and simultaneous presses in SET_H
      cur_hour = 5'd5;
      cur_min  = 6'd6;
      cur_sec  = 6'd7;
      press(1'b1, 1'b0);
      chk("enter_set_h2", {mode, load_hour, load_min, load_sec}, {2'd1, 5'd5, 6'd6, 6'd7});
      btn_inc = 1'b1;
      repeat (3) @(negedge clk);
      btn_inc = 1'b0;
      repeat (10) @(negedge clk);
      chk("short_inc_ignored", load_hour, 5);
      press(1'b1, 1'b1);
      chk("mode_wins", {mode, load_hour, load_min}, {2'd2, 5'd5, 6'd6});
      press(1'b0, 1'b1);
      chk("min_inc", load_min, 7);

      // Reset mid-edit in SET_M
      rst_n = 1'b0;
      #1;
      chk("midreset_mode", mode, 0);
      chk("midreset_pulses", {load, tick, blink}, 3'b000);
      chk("midreset_edit", {load_hour, load_min, load_sec}, {5'd8, 6'd12, 6'd17});
      repeat (2) @(negedge clk);
      chk("midreset_hold", {mode, load, tick, blink}, 5'b0);
      run_en = 1'b1;
      rst_n  = 1'b1;
      c0 = cyc;
      exp_load(c0 + 1, 8, 12, 17);
      exp_tick(c0 + 8);
      repeat (12) @(negedge clk);
      chk("post_reset_mode", mode, 0);

      @(negedge clk);
      while (q.size() > 0) begin
         fail_note("pending_expectation", -1, int'(q[0].cyc));
         void'(q.pop_front());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
